// File: rtl/bg_mapper_pkg.sv
// bg_mapper_pkg: shared types and constants for the scaled background mapper.
package bg_mapper_pkg;

    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;
    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Force a colour to black when the pixel is not to be shown.
    function automatic rgb444_t rgb_gate(input logic show, input rgb444_t c);
        return show ? c : '0;
    endfunction

endpackage

// File: rtl/bg_dda_axis.sv
// bg_dda_axis: one Bresenham nearest-neighbour stepper mapping SCREEN raster
// positions onto IMG image positions (IMG <= SCREEN), with wrap-around.
// o_pos is the position for the current raster coordinate (combinational,
// already reflecting a restart in the same cycle); o_inc/o_wrap flag that the
// step taking effect at this clock edge advances / wraps the position.
module bg_dda_axis
    import bg_mapper_pkg::*;
#(
    parameter int IMG    = 256,
    parameter int SCREEN = 640,
    localparam int POS_W = (IMG > 1) ? $clog2(IMG) : 1,
    localparam int ACC_W = $clog2(2 * SCREEN)
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_restart,
    input  logic             i_step,
    input  logic [POS_W-1:0] i_start_pos,
    output logic [POS_W-1:0] o_pos,
    output logic             o_inc,
    output logic             o_wrap
);

    logic [POS_W-1:0] r_pos;
    logic [ACC_W-1:0] r_acc;

    logic [POS_W-1:0] w_pos;
    logic [POS_W-1:0] w_pos_nxt;
    logic [ACC_W-1:0] w_acc;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_acc_nxt;

    // Current position/accumulator (restart overrides), and the stepped values
    always_comb begin
        w_pos     = i_restart ? i_start_pos : r_pos;
        w_acc     = i_restart ? '0 : r_acc;
        w_sum     = w_acc + ACC_W'(IMG);
        o_inc     = i_step && (w_sum >= ACC_W'(SCREEN));
        o_wrap    = o_inc && (w_pos == POS_W'(IMG - 1));
        w_acc_nxt = w_acc;
        w_pos_nxt = w_pos;
        if (i_step) begin
            w_acc_nxt = o_inc ? (w_sum - ACC_W'(SCREEN)) : w_sum;
        end
        if (o_inc) begin
            w_pos_nxt = o_wrap ? '0 : (w_pos + 1'b1);
        end
    end

    assign o_pos = w_pos;

    // Stepper state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos <= '0;
            r_acc <= '0;
        end else begin
            r_pos <= w_pos_nxt;
            r_acc <= w_acc_nxt;
        end
    end

endmodule

// File: rtl/scaled_background_mapper.sv
// scaled_background_mapper: maps the VGA raster onto an IMG_W x IMG_H indexed
// image, nearest-neighbour upscaled to SCREEN_W x SCREEN_H, with frame-
// synchronous wrap-around scroll. Pixel latency DrawX -> RGB is ROM_LAT+2.
// Optional build macro: TRANSPARENT_KEY_EN (pixels whose index equals KEY_IDX
// are output as black with opaque=0).
module scaled_background_mapper
    import bg_mapper_pkg::*;
#(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int IDX_W    = 4,
    parameter int ROM_LAT  = 1,
    parameter int KEY_IDX  = 0,
    localparam int ADDR_W  = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
    localparam int SX_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int SY_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1
)(
    input  logic              vga_clk,
    input  logic              reset_n,
    input  coord_t            DrawX,
    input  coord_t            DrawY,
    input  logic              blank,
    input  logic [SX_W-1:0]   scroll_x,
    input  logic [SY_W-1:0]   scroll_y,
    input  logic              scroll_we,
    output logic              scroll_busy,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [11:0]       pal_rgb,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              opaque
);

    if (IMG_W > SCREEN_W || IMG_H > SCREEN_H) begin : g_no_downscale
        $error("scaled_background_mapper: image larger than screen (downscale) is not supported");
    end
    if (ROM_LAT < 1) begin : g_rom_lat
        $error("scaled_background_mapper: ROM_LAT must be at least 1");
    end
    if (KEY_IDX < 0 || KEY_IDX >= (1 << IDX_W)) begin : g_key_range
        $error("scaled_background_mapper: KEY_IDX does not fit in IDX_W bits");
    end

    // Raster events
    logic w_line_start;
    logic w_frame_start;
    logic w_x_step;
    logic w_y_step;

    assign w_line_start  = (DrawX == '0);
    assign w_frame_start = w_line_start && (DrawY == '0);
    assign w_x_step      = (DrawX < COORD_W'(SCREEN_W));
    assign w_y_step      = (DrawX == COORD_W'(SCREEN_W)) && (DrawY < COORD_W'(SCREEN_H));

    // Scroll state: software writes pending, frame start promotes to active
    logic [SX_W-1:0] r_pend_x;
    logic [SY_W-1:0] r_pend_y;
    logic [SX_W-1:0] r_act_x;
    logic [SY_W-1:0] r_act_y;
    logic            r_busy;
    logic [SX_W-1:0] w_act_x;
    logic [SY_W-1:0] w_act_y;

    // On the frame-start cycle itself the promoted value is already in force
    assign w_act_x = w_frame_start ? r_pend_x : r_act_x;
    assign w_act_y = w_frame_start ? r_pend_y : r_act_y;

    // Pending/active scroll registers; a write on frame start stays pending
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_x <= '0;
            r_pend_y <= '0;
            r_act_x  <= '0;
            r_act_y  <= '0;
            r_busy   <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_act_x <= r_pend_x;
                r_act_y <= r_pend_y;
            end
            if (scroll_we) begin
                r_pend_x <= scroll_x;
                r_pend_y <= scroll_y;
                r_busy   <= 1'b1;
            end else if (w_frame_start) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign scroll_busy = r_busy;

    // Per-axis steppers
    logic [SX_W-1:0] w_x_pos;
    logic            w_x_inc;
    logic            w_x_wrap;
    logic [SY_W-1:0] w_y_pos;
    logic            w_y_inc;
    logic            w_y_wrap;
    logic            w_unused_x_evt;

    bg_dda_axis #(
        .IMG    (IMG_W),
        .SCREEN (SCREEN_W)
    ) u_dda_x (
        .i_clk       (vga_clk),
        .i_rst_n     (reset_n),
        .i_restart   (w_line_start),
        .i_step      (w_x_step),
        .i_start_pos (w_act_x),
        .o_pos       (w_x_pos),
        .o_inc       (w_x_inc),
        .o_wrap      (w_x_wrap)
    );

    bg_dda_axis #(
        .IMG    (IMG_H),
        .SCREEN (SCREEN_H)
    ) u_dda_y (
        .i_clk       (vga_clk),
        .i_rst_n     (reset_n),
        .i_restart   (w_frame_start),
        .i_step      (w_y_step),
        .i_start_pos (w_act_y),
        .o_pos       (w_y_pos),
        .o_inc       (w_y_inc),
        .o_wrap      (w_y_wrap)
    );

    // The X stepper's events are not needed: the column is used directly
    assign w_unused_x_evt = w_x_inc | w_x_wrap;

    // Row base: v*IMG_W tracked by adding IMG_W per row; the frame-start
    // reload is a constant-coefficient product evaluated once per frame
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] w_row_start;
    logic [ADDR_W-1:0] w_row_base;

    assign w_row_start = ADDR_W'(w_y_pos) * ADDR_W'(IMG_W);
    assign w_row_base  = w_frame_start ? w_row_start : r_row_base;

    // Row base register: reload at frame start, advance/wrap with the Y stepper
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row_base <= '0;
        end else if (w_frame_start) begin
            r_row_base <= w_row_start;
        end else if (w_y_inc) begin
            r_row_base <= w_y_wrap ? '0 : (r_row_base + ADDR_W'(IMG_W));
        end
    end

    // ---- stage p1: registered ROM address ----
    logic [ADDR_W-1:0] r_addr_p1;

    // ROM address register
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr_p1 <= '0;
        end else begin
            r_addr_p1 <= w_row_base + ADDR_W'(w_x_pos);
        end
    end

    assign rom_address = r_addr_p1;
    assign pal_index   = rom_q;

    // Active-video flag travels alongside the pixel through address + ROM stages
    logic [ROM_LAT:0] r_vld_pipe;
    logic             w_vld_d;

    // Active-video delay line (ROM_LAT+1 registers)
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[ROM_LAT-1:0], blank};
        end
    end

    assign w_vld_d = r_vld_pipe[ROM_LAT];

    logic w_show;
`ifdef TRANSPARENT_KEY_EN
    assign w_show = w_vld_d && (rom_q != IDX_W'(KEY_IDX));
`else
    assign w_show = w_vld_d;
`endif

    // ---- stage p2: registered colour output ----
    rgb444_t r_rgb_p2;
    logic    r_opaque_p2;

    // Output colour register: palette colour during active video, else black
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb_p2    <= '0;
            r_opaque_p2 <= 1'b0;
        end else begin
            r_rgb_p2    <= rgb_gate(w_show, rgb444_t'(pal_rgb));
            r_opaque_p2 <= w_show;
        end
    end

    assign red    = r_rgb_p2.r;
    assign green  = r_rgb_p2.g;
    assign blue   = r_rgb_p2.b;
    assign opaque = r_opaque_p2;

endmodule

// File: tb/tb_scaled_background_mapper.sv
// Bench for scaled_background_mapper: two instances (ROM_LAT 1 and 2) share
// the raster stimulus; a behavioural model predicts addresses and colours.
module tb_scaled_background_mapper;

    localparam int IMG_W    = 256;
    localparam int IMG_H    = 256;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int IDX_W    = 4;
    localparam int KEY_IDX  = 0;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] DrawX, DrawY;
    logic       blank;
    logic [7:0] scroll_x, scroll_y;
    logic       scroll_we;

    logic        busy_a, busy_b;
    logic [15:0] addr_a, addr_b;
    logic [3:0]  q_a, q_b, idx_a, idx_b;
    logic [11:0] pal_a, pal_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        op_a, op_b;

    always #5 clk = ~clk;

    scaled_background_mapper #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
        .IDX_W(IDX_W), .ROM_LAT(1), .KEY_IDX(KEY_IDX)
    ) dut_a (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .scroll_x(scroll_x), .scroll_y(scroll_y), .scroll_we(scroll_we), .scroll_busy(busy_a),
        .rom_address(addr_a), .rom_q(q_a), .pal_index(idx_a), .pal_rgb(pal_a),
        .red(r_a), .green(g_a), .blue(b_a), .opaque(op_a)
    );

    scaled_background_mapper #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
        .IDX_W(IDX_W), .ROM_LAT(2), .KEY_IDX(KEY_IDX)
    ) dut_b (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .scroll_x(scroll_x), .scroll_y(scroll_y), .scroll_we(scroll_we), .scroll_busy(busy_b),
        .rom_address(addr_b), .rom_q(q_b), .pal_index(idx_b), .pal_rgb(pal_b),
        .red(r_b), .green(g_b), .blue(b_b), .opaque(op_b)
    );

    // Image and palette contents
    function automatic logic [3:0] img(input int a);
        int t;
        t = ((a ^ (a >> 5)) * 5) + 3;
        return t[3:0];
    endfunction

    function automatic logic [11:0] pal(input logic [3:0] i);
        logic [3:0] pr, pg, pb;
        pr = i + 4'd1;
        pg = i ^ 4'hA;
        pb = 4'd15 - i;
        return {pr, pg, pb};
    endfunction

    // External ROMs with 1 and 2 cycles of read latency
    logic [3:0] qa_p, qb_p1, qb_p2;
    always @(posedge clk) begin
        qa_p  <= img(int'(addr_a));
        qb_p1 <= img(int'(addr_b));
        qb_p2 <= qb_p1;
    end
    assign q_a   = qa_p;
    assign q_b   = qb_p2;
    assign pal_a = pal(idx_a);
    assign pal_b = pal(idx_b);

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-cycle record of what the DUT was shown
    typedef struct packed {
        bit valid;
        bit blank;
        bit vis;
        int x;
        int y;
        int frame;
        int addr;
    } ent_t;

    ent_t hist [8];
    int   cnt = 0;
    int   m_ax = 0, m_ay = 0, m_px = 0, m_py = 0;
    bit   m_busy = 0, m_ok = 0;
    int   cur_frame = 0;

    function automatic int exp_addr(input int x, input int y, input int ax, input int ay);
        int u, v;
        u = ((x * IMG_W) / SCREEN_W + ax) % IMG_W;
        v = ((y * IMG_H) / SCREEN_H + ay) % IMG_H;
        return v * IMG_W + u;
    endfunction

    function automatic bit shown(input ent_t e);
`ifdef TRANSPARENT_KEY_EN
        return e.blank && (img(e.addr) != 4'(KEY_IDX));
`else
        return e.blank;
`endif
    endfunction

    function automatic int exp_rgb(input ent_t e);
        return shown(e) ? int'(pal(img(e.addr))) : 0;
    endfunction

    always @(posedge clk) begin
        ent_t e;
        e = '0;
        if (reset_n !== 1'b1) begin
            m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_busy = 0; m_ok = 0;
            for (int i = 0; i < 8; i++) hist[i].valid = 1'b0;
        end else begin
            if (DrawX == 0 && DrawY == 0) begin
                m_ax = m_px;
                m_ay = m_py;
                m_ok = 1;
            end
            if (scroll_we) begin
                m_px = int'(scroll_x);
                m_py = int'(scroll_y);
                m_busy = 1;
            end else if (DrawX == 0 && DrawY == 0) begin
                m_busy = 0;
            end
            e.valid = m_ok;
            e.blank = blank;
            e.x     = int'(DrawX);
            e.y     = int'(DrawY);
            e.vis   = (e.x < SCREEN_W) && (e.y < SCREEN_H);
            e.frame = cur_frame;
            e.addr  = e.vis ? exp_addr(e.x, e.y, m_ax, m_ay) : 0;
        end
        cnt++;
        hist[cnt % 8] = e;
    end

    int lit_u [6] = '{0, 0, 0, 1, 1, 2};

    // Compare process: DUT vs model on every cycle out of reset
    always @(negedge clk) begin
        ent_t e, ea, eb;
        if (reset_n === 1'b1 && cnt > 8) begin
            e  = hist[cnt % 8];
            ea = hist[(cnt - 2) % 8];
            eb = hist[(cnt - 3) % 8];
            check("busy_a", int'(busy_a), int'(m_busy));
            check("busy_b", int'(busy_b), int'(m_busy));
            if (e.valid && e.vis) begin
                check("addr_a", int'(addr_a), e.addr);
                check("addr_b", int'(addr_b), e.addr);
                if (e.frame == 0 && e.y == 0 && e.x < 6)
                    check("u_literal", int'(addr_a), lit_u[e.x]);
                if (e.frame == 1 && e.y == 0 && e.x == 0) check("scroll_00", int'(addr_a), 65535);
                if (e.frame == 1 && e.y == 0 && e.x == 3) check("scroll_30", int'(addr_a), 65280);
                if (e.frame == 1 && e.y == 2 && e.x == 0) check("scroll_02", int'(addr_a), 255);
                if (e.frame == 1 && e.y == 2 && e.x == 3) check("scroll_32", int'(addr_a), 0);
            end
            if (ea.valid) begin
                check("rgb_a", int'({r_a, g_a, b_a}), exp_rgb(ea));
                check("opaque_a", int'(op_a), int'(shown(ea)));
            end
            if (eb.valid) begin
                check("rgb_b", int'({r_b, g_b, b_b}), exp_rgb(eb));
                check("opaque_b", int'(op_b), int'(shown(eb)));
            end
        end
    end

    // Stimulus
    bit   we_req = 0;
    logic [7:0] sx_req = '0, sy_req = '0;

    task automatic step(input int x, input int y, input bit b);
        @(posedge clk);
        #1;
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        blank     = b;
        scroll_we = we_req;
        if (we_req) begin
            scroll_x = sx_req;
            scroll_y = sy_req;
        end
        we_req = 0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_addr_a"}, int'(addr_a), 0);
        check({tag, "_addr_b"}, int'(addr_b), 0);
        check({tag, "_rgb_a"}, int'({r_a, g_a, b_a}), 0);
        check({tag, "_rgb_b"}, int'({r_b, g_b, b_b}), 0);
        check({tag, "_opaque"}, int'(op_a | op_b), 0);
        check({tag, "_busy"}, int'(busy_a | busy_b), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_cleared("midrst");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_frame(input int fid, input int rst_line, input int wr_line,
                             input int n_wr, input int wr_x, input int wr_y);
        cur_frame = fid;
        for (int y = 0; y < SCREEN_H; y++) begin
            int len;
            len = (y < 3 || y == 239 || y == SCREEN_H - 1 || y == rst_line) ? SCREEN_W : 10;
            for (int x = 0; x < len; x++) begin
                if (y == wr_line && x >= 5 && x < 5 + n_wr) begin
                    we_req = 1;
                    sx_req = (wr_x < 0) ? 8'($urandom_range(0, 255)) : 8'(wr_x);
                    sy_req = (wr_y < 0) ? 8'($urandom_range(0, 255)) : 8'(wr_y);
                end
                step(x, y, 1'b1);
                if (y == wr_line && x == 5 + n_wr) begin
                    #1;
                    check("busy_after_write", int'(busy_a), 1);
                end
                if (y == rst_line && x == 300) do_reset();
            end
            step(SCREEN_W, y, 1'b0);
        end
        for (int y = SCREEN_H; y < SCREEN_H + 3; y++) step(700, y, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b0;
        DrawX     = '0;
        DrawY     = '0;
        blank     = 1'b0;
        scroll_x  = '0;
        scroll_y  = '0;
        scroll_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        reset_n = 1'b1;

        // Zero scroll; a mid-frame write of 255/255 stays pending
        run_frame(0, -1, 200, 1, 255, 255);
        // Write coincident with frame start: 255/255 applies, new value pends
        we_req = 1;
        sx_req = 8'($urandom_range(0, 255));
        sy_req = 8'($urandom_range(0, 255));
        run_frame(1, -1, 100, 3, -1, -1);
        // Last-wins value applies; write, then reset mid-frame
        run_frame(2, 100, 50, 1, -1, -1);
        // First frame after reset: zero scroll again
        run_frame(3, -1, -1, 0, 0, 0);
        run_frame(4, -1, 300, 2, 0, 0);

        // Single active pixel at frame start: colour appears after exactly
        // ROM_LAT+2 cycles and only then
        cur_frame = 5;
        step(0, 0, 1'b1);
        for (int n = 1; n <= 6; n++) begin
            step(n, 0, 1'b0);
            #1;
            check("latency_a", int'(|{r_a, g_a, b_a}), int'(n == 3));
            check("latency_b", int'(|{r_b, g_b, b_b}), int'(n == 4));
        end
        step(SCREEN_W, 0, 1'b0);
        step(SCREEN_W + 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
